// File: rtl/wfg_timer_pkg.sv
// wfg_timer_pkg: shared definitions for the WFG Wishbone timer.
//   - word offsets (adr[7:2]) of the mapped registers
//   - CTRL bit indices and the CTRL register layout (ctrl_t)
//   - COMPARE reset value
`timescale 1ns/1ps
package wfg_timer_pkg;

  localparam logic [5:0] REG_CTRL    = 6'h00;
  localparam logic [5:0] REG_PRESC   = 6'h01;
  localparam logic [5:0] REG_COMPARE = 6'h02;
  localparam logic [5:0] REG_COUNTER = 6'h03;
  localparam logic [5:0] REG_STATUS  = 6'h04;

  localparam int unsigned CTRL_EN_BIT         = 0;
  localparam int unsigned CTRL_AUTORELOAD_BIT = 1;
  localparam int unsigned CTRL_IRQ_EN_BIT     = 2;

  localparam logic [31:0] COMPARE_RST = 32'hFFFF_FFFF;

  // Field order places en at bit 0, autoreload at bit 1, irq_en at bit 2.
  typedef struct packed {
    logic irq_en;
    logic autoreload;
    logic en;
  } ctrl_t;

  function automatic logic [31:0] ctrl_to_word(input ctrl_t c);
    return {29'b0, c};
  endfunction

endpackage

// File: rtl/wfg_timer_if.sv
// wfg_timer_if: Wishbone classic single-access bus between the SoC master
// and the timer slave.
//   wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_dat_i[31:0], wbs_adr_i[31:0] : master -> slave
//   wbs_ack_o, wbs_dat_o[31:0]                                       : slave -> master
`timescale 1ns/1ps
interface wfg_timer_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_adr_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_dat_i, wbs_adr_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_dat_i, wbs_adr_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wfg_timer_prescaler.sv
// wfg_timer_prescaler: emits a one-cycle tick every presc+1 clk cycles while
// en is high. The internal count is held at zero while en is low or clr is
// asserted (presc being rewritten).
//   clk, rst (sync, active-high), en, clr, presc[PRESC_WIDTH-1:0] -> tick
`timescale 1ns/1ps
module wfg_timer_prescaler #(
  parameter int unsigned PRESC_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   clr,
  input  logic [PRESC_WIDTH-1:0] presc,
  output logic                   tick
);

  logic [PRESC_WIDTH-1:0] cnt;
  logic                   at_end;

  assign at_end = (cnt == presc);
  assign tick   = en & ~clr & at_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (!en || clr || at_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + PRESC_WIDTH'(1);
    end
  end

endmodule

// File: rtl/wfg_timer.sv
// wfg_timer: Wishbone-slave programmable timer for the WFG subsystem.
// Prescaled up-counter with compare match, optional auto-reload, sticky
// MATCH flag (write-1-to-clear) and registered level interrupt.
//   clk          wfg clock, rising edge
//   rst          synchronous active-high reset
//   wb           wfg_timer_if.slave (classic WB, ack one cycle after request)
//   interrupt_o  MATCH & CTRL.IRQ_EN, registered
// Build option: define WFG_TIMER_IRQ_EN to enable CTRL.IRQ_EN and interrupt_o;
// otherwise interrupt_o is tied low and CTRL[2] reads 0.
`timescale 1ns/1ps
module wfg_timer
  import wfg_timer_pkg::*;
#(
  parameter int unsigned CNT_WIDTH   = 32,
  parameter int unsigned PRESC_WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  wfg_timer_if.slave wb,
  output logic       interrupt_o
);

  ctrl_t                  ctrl;
  logic [PRESC_WIDTH-1:0] presc;
  logic [CNT_WIDTH-1:0]   compare;
  logic [CNT_WIDTH-1:0]   counter;
  logic                   match;
  logic                   ack;
  logic [31:0]            dat_o;
  logic [31:0]            rdata;

  logic       req;
  logic [5:0] word;
  logic       wr;
  logic       wr_ctrl, wr_presc, wr_compare, wr_counter, wr_status;
  logic       tick;
  logic       hit;
  logic       unused_adr;

  assign req  = wb.wbs_cyc_i & wb.wbs_stb_i & ~ack;
  assign word = wb.wbs_adr_i[7:2];
  assign wr   = req & wb.wbs_we_i;

  assign wr_ctrl    = wr && (word == REG_CTRL);
  assign wr_presc   = wr && (word == REG_PRESC);
  assign wr_compare = wr && (word == REG_COMPARE);
  assign wr_counter = wr && (word == REG_COUNTER);
  assign wr_status  = wr && (word == REG_STATUS);

  assign unused_adr = ^{wb.wbs_adr_i[31:8], wb.wbs_adr_i[1:0]};

  assign wb.wbs_ack_o = ack;
  assign wb.wbs_dat_o = dat_o;

  wfg_timer_prescaler #(
    .PRESC_WIDTH(PRESC_WIDTH)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (ctrl.en),
    .clr  (wr_presc),
    .presc(presc),
    .tick (tick)
  );

  assign hit = tick && (counter == compare);

  always_comb begin
    rdata = '0;
    case (word)
      REG_CTRL:    rdata = ctrl_to_word(ctrl);
      REG_PRESC:   rdata = 32'(presc);
      REG_COMPARE: rdata = 32'(compare);
      REG_COUNTER: rdata = 32'(counter);
      REG_STATUS:  rdata = {31'b0, match};
      default:     rdata = '0;
    endcase
  end

  // Software writes are placed after the tick update so that a same-cycle
  // CTRL/COUNTER write overrides the hardware update.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl    <= '0;
      presc   <= '0;
      compare <= CNT_WIDTH'(COMPARE_RST);
      counter <= '0;
      match   <= 1'b0;
      ack     <= 1'b0;
      dat_o   <= '0;
    end else begin
      ack   <= req;
      dat_o <= (req && !wb.wbs_we_i) ? rdata : '0;

      if (tick) begin
        if (counter == compare) begin
          if (ctrl.autoreload) begin
            counter <= '0;
          end else begin
            ctrl.en <= 1'b0;
          end
        end else begin
          counter <= counter + CNT_WIDTH'(1);
        end
      end

      if (wr_ctrl) begin
        ctrl.en         <= wb.wbs_dat_i[CTRL_EN_BIT];
        ctrl.autoreload <= wb.wbs_dat_i[CTRL_AUTORELOAD_BIT];
`ifdef WFG_TIMER_IRQ_EN
        ctrl.irq_en     <= wb.wbs_dat_i[CTRL_IRQ_EN_BIT];
`else
        ctrl.irq_en     <= 1'b0;
`endif
      end
      if (wr_presc)   presc   <= wb.wbs_dat_i[PRESC_WIDTH-1:0];
      if (wr_compare) compare <= wb.wbs_dat_i[CNT_WIDTH-1:0];
      if (wr_counter) counter <= wb.wbs_dat_i[CNT_WIDTH-1:0];

      // Hardware set has priority over a same-cycle write-1-to-clear.
      if (hit) begin
        match <= 1'b1;
      end else if (wr_status && wb.wbs_dat_i[0]) begin
        match <= 1'b0;
      end
    end
  end

`ifdef WFG_TIMER_IRQ_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      interrupt_o <= 1'b0;
    end else begin
      interrupt_o <= match & ctrl.irq_en;
    end
  end
`else
  assign interrupt_o = 1'b0;
`endif

endmodule

// File: tb/tb_wfg_timer.sv
`timescale 1ns/1ps
module tb_wfg_timer;
  import wfg_timer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic interrupt_o;

  wfg_timer_if wb ();

  wfg_timer #(
    .CNT_WIDTH  (32),
    .PRESC_WIDTH(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wb         (wb.slave),
    .interrupt_o(interrupt_o)
  );

  always #5 clk = ~clk;

`ifdef WFG_TIMER_IRQ_EN
  localparam logic IRQ_BUILT = 1'b1;
`else
  localparam logic IRQ_BUILT = 1'b0;
`endif

  localparam logic [31:0] A_CTRL    = 32'h0000_0000;
  localparam logic [31:0] A_PRESC   = 32'h0000_0004;
  localparam logic [31:0] A_COMPARE = 32'h0000_0008;
  localparam logic [31:0] A_COUNTER = 32'h0000_000C;
  localparam logic [31:0] A_STATUS  = 32'h0000_0010;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at a negedge; request is committed at the next posedge, then one
  // idle cycle follows so every access starts with ack low.
  task automatic wb_xfer(input logic we, input logic [31:0] adr,
                         input logic [31:0] wdata, output logic [31:0] rdata);
    int unsigned lat = 0;
    logic got = 1'b0;
    rdata = '0;
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_stb_i = 1'b1;
    wb.wbs_we_i  = we;
    wb.wbs_adr_i = adr;
    wb.wbs_dat_i = wdata;
    while (!got && lat < 8) begin
      @(negedge clk);
      lat++;
      if (wb.wbs_ack_o) begin
        got   = 1'b1;
        rdata = wb.wbs_dat_o;
      end
    end
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_stb_i = 1'b0;
    wb.wbs_we_i  = 1'b0;
    check("ack_latency", 32'(lat), 32'd1);
    @(negedge clk);
    check("ack_one_cycle", {31'b0, wb.wbs_ack_o}, 32'd0);
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] data);
    logic [31:0] dummy;
    wb_xfer(1'b1, adr, data, dummy);
  endtask

  task automatic rd(input string name, input logic [31:0] adr, input logic [31:0] exp);
    logic [31:0] r;
    wb_xfer(1'b0, adr, 32'h0, r);
    check(name, r, exp);
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  function automatic vec_t mkv(input logic we, input logic [31:0] adr, input logic [31:0] wdata,
                               input logic chk, input logic [31:0] exp);
    vec_t v;
    v.we = we; v.adr = adr; v.wdata = wdata; v.chk = chk; v.exp = exp;
    return v;
  endfunction

  vec_t vecs[20];

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    vecs[0]  = mkv(1'b0, A_CTRL,       32'h0,         1'b1, 32'h0);
    vecs[1]  = mkv(1'b0, A_PRESC,      32'h0,         1'b1, 32'h0);
    vecs[2]  = mkv(1'b0, A_COMPARE,    32'h0,         1'b1, 32'hFFFF_FFFF);
    vecs[3]  = mkv(1'b0, A_COUNTER,    32'h0,         1'b1, 32'h0);
    vecs[4]  = mkv(1'b0, A_STATUS,     32'h0,         1'b1, 32'h0);
    vecs[5]  = mkv(1'b0, 32'h20,       32'h0,         1'b1, 32'h0);
    vecs[6]  = mkv(1'b1, 32'h3C,       32'hDEAD_BEEF, 1'b0, 32'h0);
    vecs[7]  = mkv(1'b0, A_CTRL,       32'h0,         1'b1, 32'h0);
    vecs[8]  = mkv(1'b0, A_COMPARE,    32'h0,         1'b1, 32'hFFFF_FFFF);
    vecs[9]  = mkv(1'b1, A_PRESC,      32'hABCD_1234, 1'b0, 32'h0);
    vecs[10] = mkv(1'b0, A_PRESC,      32'h0,         1'b1, 32'h0000_1234);
    vecs[11] = mkv(1'b1, A_CTRL,       32'h6,         1'b0, 32'h0);
    vecs[12] = mkv(1'b0, A_CTRL,       32'h0,         1'b1, IRQ_BUILT ? 32'h6 : 32'h2);
    vecs[13] = mkv(1'b1, A_COMPARE,    32'h1234_5678, 1'b0, 32'h0);
    vecs[14] = mkv(1'b0, A_COMPARE,    32'h0,         1'b1, 32'h1234_5678);
    vecs[15] = mkv(1'b1, A_COUNTER,    32'h0000_0055, 1'b0, 32'h0);
    vecs[16] = mkv(1'b0, A_COUNTER,    32'h0,         1'b1, 32'h0000_0055);
    vecs[17] = mkv(1'b1, A_STATUS,     32'hFFFF_FFFF, 1'b0, 32'h0);
    vecs[18] = mkv(1'b0, A_STATUS,     32'h0,         1'b1, 32'h0);
    vecs[19] = mkv(1'b0, 32'h3C,       32'h0,         1'b1, 32'h0);

    wb.wbs_cyc_i = 1'b0;
    wb.wbs_stb_i = 1'b0;
    wb.wbs_we_i  = 1'b0;
    wb.wbs_adr_i = '0;
    wb.wbs_dat_i = '0;

    rst = 1'b1;
    idle(3);
    check("rst_ack",  {31'b0, wb.wbs_ack_o}, 32'd0);
    check("rst_dat",  wb.wbs_dat_o, 32'd0);
    check("rst_irq",  {31'b0, interrupt_o}, 32'd0);
    rst = 1'b0;
    idle(1);

    for (int i = 0; i < 20; i++) begin
      wb_xfer(vecs[i].we, vecs[i].adr, vecs[i].wdata, r);
      if (vecs[i].chk) check($sformatf("vec%0d", i), r, vecs[i].exp);
    end

    // Auto-reload with IRQ: PRESC=0, COMPARE=3, CTRL=0x7
    wr(A_CTRL, 32'h0);
    wr(A_PRESC, 32'h0);
    wr(A_COMPARE, 32'd3);
    wr(A_COUNTER, 32'h0);
    wr(A_CTRL, 32'h7);
    idle(3);
    check("irq_lag", {31'b0, interrupt_o}, 32'd0);
    rd("reload_counter_zero", A_COUNTER, 32'h0);
    check("irq_set", {31'b0, interrupt_o}, {31'b0, IRQ_BUILT});
    rd("reload_match", A_STATUS, 32'h1);
    rd("reload_ctrl", A_CTRL, IRQ_BUILT ? 32'h7 : 32'h3);
    wr(A_CTRL, 32'h4);
    wr(A_STATUS, 32'h1);
    check("w1c_irq_low", {31'b0, interrupt_o}, 32'd0);
    rd("w1c_status", A_STATUS, 32'h0);

    // W1C landing on the same edge as a new match: match wins
    wr(A_COUNTER, 32'h0);
    wr(A_CTRL, 32'h5);
    idle(2);
    wr(A_STATUS, 32'h1);
    rd("w1c_vs_match", A_STATUS, 32'h1);
    rd("oneshot_hold", A_COUNTER, 32'd3);
    rd("oneshot_en_clr", A_CTRL, IRQ_BUILT ? 32'h4 : 32'h0);
    check("w1c_vs_match_irq", {31'b0, interrupt_o}, {31'b0, IRQ_BUILT});

    // Prescaled one-shot: PRESC=4, COMPARE=2, CTRL=0x1
    wr(A_STATUS, 32'h1);
    wr(A_COUNTER, 32'h0);
    wr(A_COMPARE, 32'd2);
    wr(A_PRESC, 32'd4);
    wr(A_CTRL, 32'h1);
    idle(3);
    rd("presc_c0", A_COUNTER, 32'd0);
    rd("presc_c1a", A_COUNTER, 32'd1);
    idle(1);
    rd("presc_c1b", A_COUNTER, 32'd1);
    rd("presc_c2", A_COUNTER, 32'd2);
    idle(10);
    rd("presc_stop", A_COUNTER, 32'd2);
    rd("presc_en0", A_CTRL, 32'h0);
    rd("presc_match", A_STATUS, 32'h1);
    check("presc_no_irq", {31'b0, interrupt_o}, 32'd0);

    // Wrap: COUNTER=FFFF_FFFE, COMPARE=5, EN=1
    wr(A_STATUS, 32'h1);
    wr(A_PRESC, 32'h0);
    wr(A_COMPARE, 32'd5);
    wr(A_COUNTER, 32'hFFFF_FFFE);
    wr(A_CTRL, 32'h1);
    rd("wrap_max", A_COUNTER, 32'hFFFF_FFFF);
    rd("wrap_one", A_COUNTER, 32'd1);
    idle(10);
    rd("wrap_stop", A_COUNTER, 32'd5);
    rd("wrap_match", A_STATUS, 32'h1);
    rd("wrap_en0", A_CTRL, 32'h0);

    // Reset asserted with a write request pending: no ack, no commit
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_stb_i = 1'b1;
    wb.wbs_we_i  = 1'b1;
    wb.wbs_adr_i = A_COUNTER;
    wb.wbs_dat_i = 32'h77;
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_ack", {31'b0, wb.wbs_ack_o}, 32'd0);
    check("rst_mid_dat", wb.wbs_dat_o, 32'd0);
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_stb_i = 1'b0;
    wb.wbs_we_i  = 1'b0;
    rst = 1'b0;
    idle(1);
    rd("rst_mid_counter", A_COUNTER, 32'h0);
    rd("rst_mid_compare", A_COMPARE, 32'hFFFF_FFFF);
    rd("rst_mid_status", A_STATUS, 32'h0);
    check("rst_mid_irq", {31'b0, interrupt_o}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
